tick_period_monitor: RTL and testbench
======================================

// Module: tick_period_monitor
// PURPOSE
//  Consumer-side checker for the periodic one-cycle tick produced by the slow-clock divider.
//  Measures the clk_in cycles between successive tick rising edges and reports each period.
//  Flags ticks that arrive too fast, too slow or not at all, and asserts 'locked' once the
//  tick train is stable. Sits between the divider and any logic that relies on its cadence.
// PARAMETERS
//  CNT_W       21      width of period counter/period_out; must hold TIMEOUT
//  EXPECTED    500001  nominal tick spacing in clk_in cycles (rise to rise)
//  TOLERANCE   16      allowed |period-EXPECTED| for an in-range period
//  TIMEOUT     1000002 cycles without a rise before timeout; must exceed EXPECTED+TOLERANCE
//  LOCK_COUNT  4       consecutive in-range periods required to assert locked
// PORTS
//  clk_in        in   1      system clock
//  rst           in   1      asynchronous active-high reset
//  tick_in       in   1      tick from divider, synchronous to clk_in
//  clear_err     in   1      one-cycle pulse, clears sticky error flags
//  period_out    out  CNT_W  last measured period in cycles
//  period_valid  out  1      one-cycle pulse when period_out updates
//  locked        out  1      LOCK_COUNT consecutive in-range periods seen
//  err_fast      out  1      sticky: a period < EXPECTED-TOLERANCE was seen
//  err_slow      out  1      sticky: a period > EXPECTED+TOLERANCE was seen (below TIMEOUT)
//  err_timeout   out  1      sticky: TIMEOUT cycles elapsed with no rise
//  tick_count    out  16     count of tick rising edges, wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset (async, rst=1): state=S_WAIT_FIRST, tick_d=0, cnt=0, lock_run=0; all outputs 0.
//  - Edge detect: rise = tick_in & ~tick_d; tick_d registers tick_in each cycle.
//    A tick held high N cycles counts as one rise.
//  - All outputs registered; they update on the clk_in edge that samples rise=1 (latency 1).
//  - tick_count increments on every rise in every state.
//  - FSM:
//    S_WAIT_FIRST: first rise -> S_MEASURE, cnt<=1, no period_valid.
//    S_MEASURE: cnt increments each cycle without a rise. On rise: period_out<=cnt,
//      period_valid<=1, cnt<=1. When cnt reaches TIMEOUT with no rise -> S_TIMEOUT.
//    S_TIMEOUT: err_timeout<=1, locked<=0, lock_run<=0, cnt holds at TIMEOUT.
//      Next rise -> S_MEASURE, cnt<=1, no period_valid (gap unknown).
//  - Classification of each reported period P (unsigned compare, no wrap):
//    P < EXPECTED-TOLERANCE -> err_fast<=1; P > EXPECTED+TOLERANCE -> err_slow<=1.
//    Out-of-range P -> locked<=0, lock_run<=0.
//    In-range P -> lock_run increments (saturates at LOCK_COUNT);
//    locked<=1 when lock_run reaches LOCK_COUNT.
//  - period_valid is 0 in every cycle without a reported period.
//  - clear_err clears err_fast/err_slow/err_timeout.
//    If clear_err coincides with a new error event, the new error is set (set wins).
//    clear_err does not affect locked, lock_run or tick_count.
//  - A rise on the same cycle cnt reaches TIMEOUT: the rise wins, P=TIMEOUT is reported
//    (classified slow) and the state stays S_MEASURE.
//  - Reset mid-measurement discards the partial count; the first rise after reset is
//    treated as S_WAIT_FIRST.
// TESTING (sim params: EXPECTED=10, TOLERANCE=1, TIMEOUT=20, LOCK_COUNT=3, CNT_W=5)
//  1. Assert rst, toggle tick_in -> all outputs 0; release rst -> outputs stay 0 until a rise.
//  2. Rises every 10 cycles x4 -> no valid on first rise; then 3 pulses with period_out=10.
//     locked=1 after the 3rd pulse; tick_count=4.
//  3. While locked, rise spacing 8 -> period_out=8, err_fast=1, locked=0.
//     Pulse clear_err -> err_fast=0. Spacing 12 -> err_slow=1.
//  4. No rise for 20 cycles -> err_timeout=1, locked=0. Next rise gives no period_valid.
//     The following rise 10 cycles later gives period_out=10.
//  5. tick_in held high 5 cycles, repeated with 10-cycle rise spacing -> one rise per pulse.
//     period_out=10; tick_count increments by 1 per pulse.
//  6. rst pulse mid-period after lock -> locked=0, tick_count=0. First rise after reset
//     gives no period_valid. clear_err coincident with a spacing-8 period -> err_fast=1.

Source files
------------

// File: rtl/tick_period_monitor.sv
// tick_period_monitor: checks the cadence of the divider's one-cycle tick.
// Measures the rise-to-rise spacing in clk_in cycles, reports each period,
// raises sticky fast/slow/timeout errors and asserts 'locked' once the train
// has been in range for LOCK_COUNT consecutive periods.
module tick_period_monitor #(
    parameter int unsigned CNT_W      = 21,
    parameter int unsigned EXPECTED   = 500001,
    parameter int unsigned TOLERANCE  = 16,
    parameter int unsigned TIMEOUT    = 1000002,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             clear_err,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             locked,
    output logic             err_fast,
    output logic             err_slow,
    output logic             err_timeout,
    output logic [15:0]      tick_count
);

    localparam int unsigned LR_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0] P_LO      = CNT_W'(EXPECTED - TOLERANCE);
    localparam logic [CNT_W-1:0] P_HI      = CNT_W'(EXPECTED + TOLERANCE);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [LR_W-1:0]  LOCK_MAX  = LR_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        S_WAIT_FIRST = 2'd0,
        S_MEASURE    = 2'd1,
        S_TIMEOUT    = 2'd2
    } state_t;

    state_t           state;
    logic             tick_d;
    logic [CNT_W-1:0] cnt;
    logic [LR_W-1:0]  lock_run;

    logic             rise_c;
    logic             period_evt_c;
    logic             timeout_evt_c;
    logic             period_fast_c;
    logic             period_slow_c;
    logic [LR_W-1:0]  lock_run_inc_c;

    // Rising edge of the tick; a tick held high several cycles is one rise.
    assign rise_c = tick_in & ~tick_d;

    // A period is reported only on a rise while measuring; cnt holds that period.
    assign period_evt_c  = (state == S_MEASURE) && rise_c;
    assign period_fast_c = (cnt < P_LO);
    assign period_slow_c = (cnt > P_HI);

    // Timeout is signalled on the expiring cycle and every quiet cycle after it.
    assign timeout_evt_c = !rise_c &&
                           (((state == S_MEASURE) && (cnt == TIMEOUT_C)) ||
                            (state == S_TIMEOUT));

    // Saturating increment of the consecutive in-range run.
    assign lock_run_inc_c = (lock_run == LOCK_MAX) ? lock_run : lock_run + LR_W'(1);

    // Edge-detect history register.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            tick_d <= 1'b0;
        end else begin
            tick_d <= tick_in;
        end
    end

    // Count every tick rise regardless of state; wraps naturally.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            tick_count <= 16'd0;
        end else if (rise_c) begin
            tick_count <= tick_count + 16'd1;
        end
    end

    // Period measurement FSM; a rise on the expiring cycle beats the timeout.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state        <= S_WAIT_FIRST;
            cnt          <= '0;
            period_out   <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            case (state)
                S_WAIT_FIRST: begin
                    if (rise_c) begin
                        state <= S_MEASURE;
                        cnt   <= CNT_ONE;
                    end
                end
                S_MEASURE: begin
                    if (rise_c) begin
                        period_out   <= cnt;
                        period_valid <= 1'b1;
                        cnt          <= CNT_ONE;
                    end else if (cnt == TIMEOUT_C) begin
                        state <= S_TIMEOUT;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_TIMEOUT: begin
                    // The gap before this rise is unknown, so nothing is reported.
                    if (rise_c) begin
                        state <= S_MEASURE;
                        cnt   <= CNT_ONE;
                    end
                end
                default: begin
                    state <= S_WAIT_FIRST;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Lock tracking: in-range periods build the run, anything else breaks it.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            lock_run <= '0;
            locked   <= 1'b0;
        end else if (timeout_evt_c) begin
            lock_run <= '0;
            locked   <= 1'b0;
        end else if (period_evt_c) begin
            if (period_fast_c || period_slow_c) begin
                lock_run <= '0;
                locked   <= 1'b0;
            end else begin
                lock_run <= lock_run_inc_c;
                if (lock_run_inc_c == LOCK_MAX) begin
                    locked <= 1'b1;
                end
            end
        end
    end

    // Sticky error flags; a new error event takes priority over clear_err.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            err_fast    <= 1'b0;
            err_slow    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            err_fast    <= (period_evt_c && period_fast_c) || (err_fast    && !clear_err);
            err_slow    <= (period_evt_c && period_slow_c) || (err_slow    && !clear_err);
            err_timeout <= timeout_evt_c                   || (err_timeout && !clear_err);
        end
    end

endmodule

// File: tb/tb_tick_period_monitor.sv
// Directed bench for tick_period_monitor with small simulation parameters.
module tb_tick_period_monitor;

    localparam int unsigned CNT_W      = 5;
    localparam int unsigned EXPECTED   = 10;
    localparam int unsigned TOLERANCE  = 1;
    localparam int unsigned TIMEOUT    = 20;
    localparam int unsigned LOCK_COUNT = 3;

    logic             clk_in;
    logic             rst;
    logic             tick_in;
    logic             clear_err;
    logic [CNT_W-1:0] period_out;
    logic             period_valid;
    logic             locked;
    logic             err_fast;
    logic             err_slow;
    logic             err_timeout;
    logic [15:0]      tick_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    tick_period_monitor #(
        .CNT_W     (CNT_W),
        .EXPECTED  (EXPECTED),
        .TOLERANCE (TOLERANCE),
        .TIMEOUT   (TIMEOUT),
        .LOCK_COUNT(LOCK_COUNT)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .tick_in     (tick_in),
        .clear_err   (clear_err),
        .period_out  (period_out),
        .period_valid(period_valid),
        .locked      (locked),
        .err_fast    (err_fast),
        .err_slow    (err_slow),
        .err_timeout (err_timeout),
        .tick_count  (tick_count)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Compare one observed value against its hand-computed expectation.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Advance to 1 time unit after the next rising clock edge.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Called just after the edge that sampled the previous rise. Produces the
    // next rise exactly s edges later with tick high for h edges per pulse;
    // clear_err is sampled on edge c (c = 0 means no clear).
    task automatic rise_after(input int s, input int h, input int c);
        for (int i = 1; i <= s; i++) begin
            tick_in   = ((i < h) || (i == s)) ? 1'b1 : 1'b0;
            clear_err = (i == c) ? 1'b1 : 1'b0;
            step();
        end
        clear_err = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_period_out"},   32'(period_out),   32'd0);
        chk({tag, "_period_valid"}, 32'(period_valid), 32'd0);
        chk({tag, "_locked"},       32'(locked),       32'd0);
        chk({tag, "_errs"},         32'({err_fast, err_slow, err_timeout}), 32'd0);
        chk({tag, "_tick_count"},   32'(tick_count),   32'd0);
    endtask

    // Hard bound on simulated time.
    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        tick_in   = 1'b0;
        clear_err = 1'b0;

        // 1. Reset holds everything at zero even with tick activity.
        for (int i = 0; i < 4; i++) begin
            tick_in = ~tick_in;
            step();
        end
        chk_all_zero("rst_held");
        tick_in = 1'b0;
        rst     = 1'b0;
        step_n(3);
        chk_all_zero("rst_released");

        // 2. Four rises spaced 10: first gives no period, lock on the third period.
        tick_in = 1'b1;
        step();
        chk("first_rise_valid", 32'(period_valid), 32'd0);
        chk("first_rise_count", 32'(tick_count),   32'd1);
        rise_after(10, 1, 0);
        chk("p1_valid",  32'(period_valid), 32'd1);
        chk("p1_period", 32'(period_out),   32'd10);
        chk("p1_locked", 32'(locked),       32'd0);
        rise_after(10, 1, 0);
        chk("p2_locked", 32'(locked),       32'd0);
        rise_after(10, 1, 0);
        chk("p3_period", 32'(period_out),   32'd10);
        chk("p3_locked", 32'(locked),       32'd1);
        chk("p3_count",  32'(tick_count),   32'd4);

        // 3. Fast period breaks lock; clear_err then a slow period.
        rise_after(8, 1, 0);
        chk("fast_period", 32'(period_out), 32'd8);
        chk("fast_err",    32'(err_fast),   32'd1);
        chk("fast_locked", 32'(locked),     32'd0);
        chk("fast_slow0",  32'(err_slow),   32'd0);
        rise_after(12, 1, 2);
        chk("slow_period",  32'(period_out), 32'd12);
        chk("slow_err",     32'(err_slow),   32'd1);
        chk("cleared_fast", 32'(err_fast),   32'd0);
        chk("slow_count",   32'(tick_count), 32'd6);

        // Re-lock before the timeout test.
        rise_after(10, 1, 0);
        rise_after(10, 1, 0);
        rise_after(10, 1, 0);
        chk("relock", 32'(locked), 32'd1);

        // 4. Timeout after 20 quiet cycles, not before.
        tick_in = 1'b0;
        step_n(19);
        chk("pre_timeout_err",    32'(err_timeout),  32'd0);
        chk("pre_timeout_locked", 32'(locked),       32'd1);
        chk("no_pulse_valid",     32'(period_valid), 32'd0);
        step();
        chk("timeout_err",    32'(err_timeout), 32'd1);
        chk("timeout_locked", 32'(locked),      32'd0);
        step_n(3);
        chk("timeout_sticky", 32'(err_timeout), 32'd1);
        tick_in = 1'b1;
        step();
        chk("after_to_valid", 32'(period_valid), 32'd0);
        chk("after_to_count", 32'(tick_count),   32'd10);
        rise_after(10, 1, 0);
        chk("after_to_p_valid", 32'(period_valid), 32'd1);
        chk("after_to_period",  32'(period_out),   32'd10);

        // Rise exactly when the count reaches TIMEOUT: reported as slow, no timeout.
        rise_after(20, 1, 2);
        chk("edge_to_valid",  32'(period_valid), 32'd1);
        chk("edge_to_period", 32'(period_out),   32'd20);
        chk("edge_to_slow",   32'(err_slow),     32'd1);
        chk("edge_to_noto",   32'(err_timeout),  32'd0);
        rise_after(10, 1, 0);
        chk("post_edge_valid", 32'(period_valid), 32'd1);
        chk("post_edge_count", 32'(tick_count),   32'd13);

        // 5. Ticks held high 5 cycles: one rise per pulse.
        rise_after(10, 5, 0);
        chk("held1_period", 32'(period_out), 32'd10);
        chk("held1_count",  32'(tick_count), 32'd14);
        chk("held1_locked", 32'(locked),     32'd0);
        rise_after(10, 5, 0);
        chk("held2_period", 32'(period_out), 32'd10);
        chk("held2_count",  32'(tick_count), 32'd15);
        chk("held2_locked", 32'(locked),     32'd1);

        // 6. Reset mid-period, then clear_err coinciding with a fast period.
        tick_in = 1'b0;
        step_n(3);
        rst = 1'b1;
        #2;
        chk("midrst_locked", 32'(locked),     32'd0);
        chk("midrst_count",  32'(tick_count), 32'd0);
        chk("midrst_slow",   32'(err_slow),   32'd0);
        step();
        rst = 1'b0;
        step_n(2);
        tick_in = 1'b1;
        step();
        chk("rst_first_valid", 32'(period_valid), 32'd0);
        chk("rst_first_count", 32'(tick_count),   32'd1);
        rise_after(8, 1, 8);
        chk("setwins_valid",  32'(period_valid), 32'd1);
        chk("setwins_period", 32'(period_out),   32'd8);
        chk("setwins_fast",   32'(err_fast),     32'd1);
        tick_in = 1'b0;
        step();
        chk("valid_drops", 32'(period_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
